fifo_mc: RTL and testbench

FIFO_MC -- requirements
Module: fifo_mc

---
 rtl/fifo_mc_pkg.sv | 33 +++
 rtl/fifo_ch.sv | 108 ++++++++++
 rtl/fifo_mc.sv | 68 ++++++
 tb/tb_fifo_mc.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_mc_pkg.sv
//----------------------------------------------------------------------------
// fifo_mc_pkg
// Shared defaults, width helpers and read-mode encoding for the multi-channel FIFO.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

package fifo_mc_pkg;

    localparam int C_NUM_CH    = 4;
    localparam int C_DEPTH     = 8;
    localparam int C_WORD_SIZE = 6;
    localparam int C_PTR_L     = 3;

    typedef enum logic {
        RD_REG  = 1'b0,
        RD_FWFT = 1'b1
    } rd_mode_e;

    localparam int C_FWFT = int'(RD_REG);

    // Count needs one extra bit so that DEPTH itself is representable.
    function automatic int cnt_width(input int ptr_l);
        return ptr_l + 1;
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ch.sv
//----------------------------------------------------------------------------
// fifo_ch
// Single FIFO channel: storage, pointers, occupancy, status flags, sticky error.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module fifo_ch
    import fifo_mc_pkg::*;
#(
    parameter int DEPTH     = C_DEPTH,
    parameter int WORD_SIZE = C_WORD_SIZE,
    parameter int PTR_L     = C_PTR_L,
    parameter int FWFT      = C_FWFT
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic                 err_clr_i,
    input  logic [WORD_SIZE-1:0] data_i,
    input  logic [PTR_L:0]       full_thr_i,
    input  logic [PTR_L:0]       empty_thr_i,
    output logic [WORD_SIZE-1:0] data_o,
    output logic                 valid_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 afull_o,
    output logic                 aempty_o,
    output logic [PTR_L:0]       count_o,
    output logic                 error_o
);

    localparam int             CW       = cnt_width(PTR_L);
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

    logic [WORD_SIZE-1:0] mem_q [DEPTH];
    logic [PTR_L-1:0]     wr_ptr_q;
    logic [PTR_L-1:0]     rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        count_d;
    logic                 error_q;
    logic                 error_d;
    logic                 push_ok;
    logic                 pop_ok;

    always_comb begin
        full_o   = (count_q == FULL_CNT);
        empty_o  = (count_q == '0);
        afull_o  = (count_q >= full_thr_i);
        aempty_o = (count_q <= empty_thr_i);
        count_o  = count_q;
        error_o  = error_q;
        push_ok  = push_i & ~full_o;
        pop_ok   = pop_i & ~empty_o;
        // A fresh overflow/underflow outranks a clear in the same cycle.
        error_d  = (push_i & full_o) | (pop_i & empty_o) | (error_q & ~err_clr_i);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_L'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_L'(1);
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !reset_L) mem_q[wr_ptr_q] <= data_i;
    end

    generate
        if (FWFT == int'(RD_FWFT)) begin : g_fwft
            assign data_o  = mem_q[rd_ptr_q];
            assign valid_o = ~empty_o;
        end else begin : g_reg
            logic [WORD_SIZE-1:0] dout_q;
            logic                 valid_q;

            always_ff @(posedge clk) begin
                if (reset_L) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= pop_ok;
                    if (pop_ok) dout_q <= mem_q[rd_ptr_q];
                end
            end

            assign data_o  = dout_q;
            assign valid_o = valid_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/fifo_mc.sv
//----------------------------------------------------------------------------
// fifo_mc
// Multi-channel FIFO: write demux to NUM_CH independent channels, packed outputs.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module fifo_mc
    import fifo_mc_pkg::*;
#(
    parameter int NUM_CH    = C_NUM_CH,
    parameter int DEPTH     = C_DEPTH,
    parameter int WORD_SIZE = C_WORD_SIZE,
    parameter int PTR_L     = C_PTR_L,
    parameter int FWFT      = C_FWFT
) (
    input  logic                          clk,
    input  logic                          reset_L,
    input  logic                          fifo_wr,
    input  logic [$clog2(NUM_CH)-1:0]     wr_ch,
    input  logic [WORD_SIZE-1:0]          fifo_data_in,
    input  logic [NUM_CH-1:0]             fifo_rd,
    output logic [NUM_CH*WORD_SIZE-1:0]   fifo_data_out,
    output logic [NUM_CH-1:0]             data_valid,
    input  logic [PTR_L:0]                full_threshold,
    input  logic [PTR_L:0]                empty_threshold,
    output logic [NUM_CH-1:0]             fifo_full,
    output logic [NUM_CH-1:0]             fifo_empty,
    output logic [NUM_CH-1:0]             almost_full,
    output logic [NUM_CH-1:0]             almost_empty,
    output logic [NUM_CH*(PTR_L+1)-1:0]   occupancy,
    output logic [NUM_CH-1:0]             error,
    input  logic                          err_clr
);

    localparam int CH_W = $clog2(NUM_CH);

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            fifo_ch #(
                .DEPTH     (DEPTH),
                .WORD_SIZE (WORD_SIZE),
                .PTR_L     (PTR_L),
                .FWFT      (FWFT)
            ) u_ch (
                .clk         (clk),
                .reset_L     (reset_L),
                .push_i      (fifo_wr && (wr_ch == CH_W'(c))),
                .pop_i       (fifo_rd[c]),
                .err_clr_i   (err_clr),
                .data_i      (fifo_data_in),
                .full_thr_i  (full_threshold),
                .empty_thr_i (empty_threshold),
                .data_o      (fifo_data_out[c*WORD_SIZE +: WORD_SIZE]),
                .valid_o     (data_valid[c]),
                .full_o      (fifo_full[c]),
                .empty_o     (fifo_empty[c]),
                .afull_o     (almost_full[c]),
                .aempty_o    (almost_empty[c]),
                .count_o     (occupancy[c*(PTR_L+1) +: PTR_L+1]),
                .error_o     (error[c])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fifo_mc.sv
//----------------------------------------------------------------------------
// tb_fifo_mc
// Self-checking bench: registered-read and FWFT instances share stimulus.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_fifo_mc;

    localparam int NCH = 4;
    localparam int DEP = 8;
    localparam int WS  = 6;
    localparam int PL  = 3;

    logic              clk = 1'b0;
    logic              reset_L;
    logic              fifo_wr;
    logic [1:0]        wr_ch;
    logic [WS-1:0]     fifo_data_in;
    logic [NCH-1:0]    fifo_rd;
    logic [PL:0]       full_threshold;
    logic [PL:0]       empty_threshold;
    logic              err_clr;

    logic [NCH*WS-1:0]     dout0, dout1;
    logic [NCH-1:0]        dv0, dv1, ff0, ff1, fe0, fe1, af0, af1, ae0, ae1, err0, err1;
    logic [NCH*(PL+1)-1:0] occ0, occ1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WS-1:0] mdl   [NCH][$];
    logic [WS-1:0] exp_q [NCH][$];
    logic          merr  [NCH];

    always #5 clk = ~clk;

    fifo_mc #(.NUM_CH(NCH), .DEPTH(DEP), .WORD_SIZE(WS), .PTR_L(PL), .FWFT(0)) dut (
        .clk(clk), .reset_L(reset_L), .fifo_wr(fifo_wr), .wr_ch(wr_ch),
        .fifo_data_in(fifo_data_in), .fifo_rd(fifo_rd), .fifo_data_out(dout0),
        .data_valid(dv0), .full_threshold(full_threshold), .empty_threshold(empty_threshold),
        .fifo_full(ff0), .fifo_empty(fe0), .almost_full(af0), .almost_empty(ae0),
        .occupancy(occ0), .error(err0), .err_clr(err_clr)
    );

    fifo_mc #(.NUM_CH(NCH), .DEPTH(DEP), .WORD_SIZE(WS), .PTR_L(PL), .FWFT(1)) dut_f (
        .clk(clk), .reset_L(reset_L), .fifo_wr(fifo_wr), .wr_ch(wr_ch),
        .fifo_data_in(fifo_data_in), .fifo_rd(fifo_rd), .fifo_data_out(dout1),
        .data_valid(dv1), .full_threshold(full_threshold), .empty_threshold(empty_threshold),
        .fifo_full(ff1), .fifo_empty(fe1), .almost_full(af1), .almost_empty(ae1),
        .occupancy(occ1), .error(err1), .err_clr(err_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Registered-read scoreboard: every data_valid pulse consumes one expected word.
    always @(negedge clk) begin
        if (!reset_L) begin
            for (int c = 0; c < NCH; c++) begin
                if (exp_q[c].size() > 0) begin
                    check($sformatf("rd_valid_ch%0d", c), 32'(dv0[c]), 32'd1);
                    check($sformatf("rd_data_ch%0d", c), 32'(dout0[c*WS +: WS]), 32'(exp_q[c][0]));
                    exp_q[c].delete(0);
                end else if (dv0[c]) begin
                    check($sformatf("spurious_valid_ch%0d", c), 32'(dv0[c]), 32'd0);
                end
            end
        end
    end

    task automatic cyc(input logic wr, input logic [1:0] ch, input logic [WS-1:0] d,
                       input logic [NCH-1:0] rd, input logic ec);
        int  sz;
        bit  f, e, pw, pr;
        fifo_wr      = wr;
        wr_ch        = ch;
        fifo_data_in = d;
        fifo_rd      = rd;
        err_clr      = ec;
        @(posedge clk);
        for (int c = 0; c < NCH; c++) begin
            sz = mdl[c].size();
            f  = (sz == DEP);
            e  = (sz == 0);
            pw = wr && (int'(ch) == c);
            pr = rd[c];
            if (ec) merr[c] = 1'b0;
            if ((pw && f) || (pr && e)) merr[c] = 1'b1;
            if (pr && !e) begin
                exp_q[c].push_back(mdl[c][0]);
                mdl[c].delete(0);
            end
            if (pw && !f) mdl[c].push_back(d);
        end
        #1;
        fifo_wr = 1'b0;
        fifo_rd = '0;
        err_clr = 1'b0;
    endtask

    task automatic do_reset();
        reset_L = 1'b1;
        @(posedge clk);
        #1;
        reset_L = 1'b0;
        fifo_wr = 1'b0;
        fifo_rd = '0;
        err_clr = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            mdl[c].delete();
            exp_q[c].delete();
            merr[c] = 1'b0;
        end
    endtask

    task automatic check_state(input string where);
        int cnt;
        for (int c = 0; c < NCH; c++) begin
            cnt = mdl[c].size();
            check($sformatf("%s occ%0d", where, c), 32'(occ0[c*(PL+1) +: PL+1]), 32'(cnt));
            check($sformatf("%s full%0d", where, c), 32'(ff0[c]), 32'(cnt == DEP));
            check($sformatf("%s empty%0d", where, c), 32'(fe0[c]), 32'(cnt == 0));
            check($sformatf("%s afull%0d", where, c), 32'(af0[c]), 32'(cnt >= int'(full_threshold)));
            check($sformatf("%s aempty%0d", where, c), 32'(ae0[c]), 32'(cnt <= int'(empty_threshold)));
            check($sformatf("%s err%0d", where, c), 32'(err0[c]), 32'(merr[c]));
            check($sformatf("%s f_occ%0d", where, c), 32'(occ1[c*(PL+1) +: PL+1]), 32'(cnt));
            check($sformatf("%s f_valid%0d", where, c), 32'(dv1[c]), 32'(cnt != 0));
            if (cnt != 0)
                check($sformatf("%s f_head%0d", where, c), 32'(dout1[c*WS +: WS]), 32'(mdl[c][0]));
        end
    endtask

    initial begin
        fifo_wr         = 1'b0;
        wr_ch           = '0;
        fifo_data_in    = '0;
        fifo_rd         = '0;
        err_clr         = 1'b0;
        full_threshold  = 4'd8;
        empty_threshold = 4'd0;
        do_reset();
        check_state("reset");
        check("reset dv", 32'(dv0), 32'd0);
        check("reset dout", dout0, 32'd0);

        // Fill ch2 to full, then overflow and clear.
        for (int i = 1; i <= 8; i++) cyc(1'b1, 2'd2, WS'(i), '0, 1'b0);
        check_state("fill2");
        cyc(1'b1, 2'd2, 6'd9, '0, 1'b0);
        check_state("ovf2");
        cyc(1'b0, 2'd0, '0, '0, 1'b1);
        check_state("clr2");

        // Drain ch2 in order, then underflow with a clear in the same cycle.
        for (int i = 0; i < 8; i++) cyc(1'b0, 2'd0, '0, 4'b0100, 1'b0);
        cyc(1'b0, 2'd0, '0, '0, 1'b0);
        check_state("drain2");
        cyc(1'b0, 2'd0, '0, 4'b0100, 1'b1);
        check_state("udf2");
        cyc(1'b0, 2'd0, '0, '0, 1'b1);

        // Ch0 steady at 4 entries with concurrent push/pop across pointer wrap.
        for (int i = 0; i < 4; i++) cyc(1'b1, 2'd0, WS'(6'h10 + i), '0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 2'd0, WS'(6'h2A ^ i), 4'b0001, 1'b0);
            check($sformatf("pp_occ0_%0d", i), 32'(occ0[3:0]), 32'd4);
        end
        check_state("pushpop0");

        // Full ch3 with concurrent push and pop: only the pop is taken.
        for (int i = 0; i < 8; i++) cyc(1'b1, 2'd3, WS'(6'h30 + i), '0, 1'b0);
        cyc(1'b1, 2'd3, 6'h3F, 4'b1000, 1'b0);
        check_state("fullpp3");
        cyc(1'b0, 2'd0, '0, '0, 1'b1);

        // Threshold sweep on ch1, counts 0..8.
        do_reset();
        full_threshold  = 4'd6;
        empty_threshold = 4'd2;
        check_state("thr0");
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 2'd1, WS'(i - 1), '0, 1'b0);
            check_state($sformatf("thr%0d", i));
        end

        // FWFT visibility one cycle after push, then reset mid-stream.
        cyc(1'b1, 2'd3, 6'h15, '0, 1'b0);
        check("fwft dv3", 32'(dv1[3]), 32'd1);
        check("fwft dout3", 32'(dout1[3*WS +: WS]), 32'h15);
        cyc(1'b1, 2'd1, 6'h01, '0, 1'b0);
        fifo_wr = 1'b1;
        wr_ch   = 2'd0;
        fifo_rd = 4'b0010;
        err_clr = 1'b1;
        do_reset();
        check_state("midreset");
        check("midreset dv", 32'(dv0), 32'd0);
        check("midreset dout", dout0, 32'd0);

        cyc(1'b0, 2'd0, '0, '0, 1'b0);
        for (int c = 0; c < NCH; c++)
            check($sformatf("pending_ch%0d", c), 32'(exp_q[c].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
